hazard_control_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Issues every PC / IF-ID / ID-EX write, flush and bubble, and gates the global pipeline enable.
- Detects load-use hazards (the one case operand forwarding cannot cover), applies branch flushes, drains and halts on HALT, and supports debug single-step.
- Sits in ID; consumes ID/EX register fields plus debug-unit controls.

---
 rtl/hazard_control_unit_pkg.sv | 24 ++
 rtl/hcu_loaduse_detect.sv | 19 +
 rtl/hazard_control_unit.sv | 128 ++++++++++++
 tb/tb_hazard_control_unit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared state encodings and pipeline control patterns
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_WAIT = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_HALTED    = 2'd3
  } hcu_state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } hcu_ctrl_t;

  localparam hcu_ctrl_t HCU_CTRL_IDLE   = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam hcu_ctrl_t HCU_CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam hcu_ctrl_t HCU_CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};
  // NOP injection into ID/EX: freeze front end, load bubble control.
  localparam hcu_ctrl_t HCU_CTRL_BUBBLE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};

endpackage

// File: rtl/hcu_loaduse_detect.sv
// rtl/hcu_loaduse_detect.sv - combinational load-use hazard compare between ID and EX
module hcu_loaduse_detect (
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] exe_rt_i,
  input  logic       exe_mem_read_i,
  output logic       loaduse_o
);

  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency, so a load to r0 cannot stall.
  assign rs_hit    = (exe_rt_i == id_rs_i);
  assign rt_hit    = id_uses_rt_i && (exe_rt_i == id_rt_i);
  assign loaduse_o = exe_mem_read_i && (exe_rt_i != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline sequencing: load-use stall, branch flush, halt drain, debug step
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       I_HCU_ID_RS,
  input  logic [4:0]       I_HCU_ID_RT,
  input  logic             I_HCU_ID_UsesRT,
  input  logic [4:0]       I_HCU_EXE_RT,
  input  logic             I_HCU_EXE_MemRead,
  input  logic             I_HCU_ID_BranchTaken,
  input  logic             I_HCU_ID_Halt,
  input  logic             I_HCU_DBG_Mode,
  input  logic             I_HCU_DBG_Step,
  output logic             O_HCU_PipeEnable,
  output logic             O_HCU_PC_Write,
  output logic             O_HCU_IFID_Write,
  output logic             O_HCU_IFID_Flush,
  output logic             O_HCU_IDEX_Bubble,
  output logic             O_HCU_Halted,
  output logic [CNT_W-1:0] O_HCU_StallCount,
  output logic [1:0]       O_HCU_State
);

  localparam int             DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]  DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  hcu_state_e       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             step_q;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic      loaduse;
  logic      advance;
  logic      decode_act;
  logic      halt_win;
  hcu_ctrl_t ctrl;

  hcu_loaduse_detect u_loaduse (
    .id_rs_i        (I_HCU_ID_RS),
    .id_rt_i        (I_HCU_ID_RT),
    .id_uses_rt_i   (I_HCU_ID_UsesRT),
    .exe_rt_i       (I_HCU_EXE_RT),
    .exe_mem_read_i (I_HCU_EXE_MemRead),
    .loaduse_o      (loaduse)
  );

  always_comb begin
    advance = 1'b0;
    case (state_q)
      ST_RUN:       advance = 1'b1;
      ST_STEP_WAIT: advance = I_HCU_DBG_Step && !step_q;
      ST_DRAIN:     advance = 1'b1;
      default:      advance = 1'b0;
    endcase
  end

  // Hazard decode only matters when an instruction actually moves out of ID.
  assign decode_act = advance && ((state_q == ST_RUN) || (state_q == ST_STEP_WAIT));
  assign halt_win   = decode_act && !loaduse && !I_HCU_ID_BranchTaken && I_HCU_ID_Halt;

  always_comb begin
    ctrl = HCU_CTRL_IDLE;
    if (decode_act) begin
      if (loaduse)                   ctrl = HCU_CTRL_BUBBLE;
      else if (I_HCU_ID_BranchTaken) ctrl = HCU_CTRL_FLUSH;
      else if (I_HCU_ID_Halt)        ctrl = HCU_CTRL_BUBBLE;
      else                           ctrl = HCU_CTRL_RUN;
    end else if (state_q == ST_DRAIN) begin
      ctrl = HCU_CTRL_BUBBLE;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN, ST_STEP_WAIT: begin
        if (halt_win) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if ((state_q == ST_RUN) && I_HCU_DBG_Mode) begin
          state_d = ST_STEP_WAIT;
        end else if ((state_q == ST_STEP_WAIT) && !I_HCU_DBG_Mode) begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) state_d = ST_HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (decode_act && loaduse && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      step_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      step_q  <= I_HCU_DBG_Step;
      stall_q <= stall_d;
    end
  end

  assign O_HCU_PipeEnable  = advance;
  assign O_HCU_PC_Write    = ctrl.pc_write;
  assign O_HCU_IFID_Write  = ctrl.ifid_write;
  assign O_HCU_IFID_Flush  = ctrl.ifid_flush;
  assign O_HCU_IDEX_Bubble = ctrl.idex_bubble;
  assign O_HCU_Halted      = (state_q == ST_HALTED);
  assign O_HCU_StallCount  = stall_q;
  assign O_HCU_State       = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_rt;
  logic       uses_rt, mem_read, br_taken, halt, dbg_mode, dbg_step;
  logic       pipe_en, pc_wr, ifid_wr, ifid_fl, idex_bub, halted;
  logic [3:0] stall_cnt;
  logic [1:0] state;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .CLK                  (clk),
    .RESET                (rst),
    .I_HCU_ID_RS          (id_rs),
    .I_HCU_ID_RT          (id_rt),
    .I_HCU_ID_UsesRT      (uses_rt),
    .I_HCU_EXE_RT         (exe_rt),
    .I_HCU_EXE_MemRead    (mem_read),
    .I_HCU_ID_BranchTaken (br_taken),
    .I_HCU_ID_Halt        (halt),
    .I_HCU_DBG_Mode       (dbg_mode),
    .I_HCU_DBG_Step       (dbg_step),
    .O_HCU_PipeEnable     (pipe_en),
    .O_HCU_PC_Write       (pc_wr),
    .O_HCU_IFID_Write     (ifid_wr),
    .O_HCU_IFID_Flush     (ifid_fl),
    .O_HCU_IDEX_Bubble    (idex_bub),
    .O_HCU_Halted         (halted),
    .O_HCU_StallCount     (stall_cnt),
    .O_HCU_State          (state)
  );

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic [4:0] ert, input logic mr, input logic br, input logic hl,
                       input logic md, input logic st);
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; uses_rt = uses; exe_rt = ert;
    mem_read = mr; br_taken = br; halt = hl; dbg_mode = md; dbg_step = st;
  endtask

  // Expected vector: {state, pe, pc_wr, ifid_wr, flush, bubble, halted, stall_cnt}
  task automatic exp_out(input string n, input logic [1:0] s, input logic pe, input logic pc,
                         input logic iw, input logic fl, input logic bb, input logic hh,
                         input logic [3:0] c);
    exp_q.push_back({s, pe, pc, iw, fl, bb, hh, c});
    name_q.push_back(n);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {state, pipe_en, pc_wr, ifid_wr, ifid_fl, idex_bub, halted, stall_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d pe/pc/ifid/fl/bub/halt=%b cnt=%0d, want st=%0d pe/pc/ifid/fl/bub/halt=%b cnt=%0d",
                 n, a[11:10], a[9:4], a[3:0], e[11:10], e[9:4], e[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; exe_rt = '0;
    uses_rt = 1'b0; mem_read = 1'b0; br_taken = 1'b0; halt = 1'b0; dbg_mode = 1'b0; dbg_step = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("reset",    0, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 2, 0, 0, 2, 1, 0, 0, 0, 0); exp_out("lu_rs",    0, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("lu_cnt",   0, 1, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0); exp_out("lu_rt0",   0, 1, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 5, 0, 5, 1, 0, 0, 0, 0); exp_out("rt_nouse", 0, 1, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 5, 1, 5, 1, 0, 0, 0, 0); exp_out("rt_use",   0, 1, 0, 0, 0, 1, 0, 1);
    drive(0, 3, 0, 0, 3, 1, 1, 0, 0, 0); exp_out("lu_br",    0, 1, 0, 0, 0, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exp_out("br",       0, 1, 1, 1, 1, 0, 0, 3);

    for (int i = 0; i < 19; i++) begin
      drive(0, 7, 0, 0, 7, 1, 0, 0, 0, 0);
      exp_out("sat", 0, 1, 0, 0, 0, 1, 0, (3 + i > 15) ? 4'd15 : 4'(3 + i));
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("sat_hold", 0, 1, 1, 1, 0, 0, 0, 15);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("post_rst", 0, 1, 1, 1, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_out("mode_run",   0, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_out("sw_idle",    1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 2, 0, 0, 2, 1, 0, 0, 1, 1); exp_out("sw_lu",      1, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 2, 0, 0, 2, 1, 0, 0, 1, 1); exp_out("sw_hold_lu", 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp_out("sw_hold", 1, 0, 0, 0, 0, 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_out("sw_low",     1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp_out("sw_step2",   1, 1, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); exp_out("sw_exit",    1, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("run_again",  0, 1, 1, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("run_cont",   0, 1, 1, 1, 0, 0, 0, 1);

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_out("halt_id",    0, 1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2, 0, 0, 2, 1, 1, 0, 1, 1); exp_out("drain", 2, 1, 0, 0, 0, 1, 0, 1);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 2, 2, 1, 2, 1, i[0], 1, i[0], i[0]); exp_out("halted", 3, 0, 0, 0, 0, 0, 1, 1);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("halt_rst",  0, 1, 1, 1, 0, 0, 0, 0);

    drive(0, 4, 0, 0, 4, 1, 0, 0, 0, 0); exp_out("lu_again",  0, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exp_out("halt2",     0, 1, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("drain2",    2, 1, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exp_out("drain_rst", 0, 1, 1, 1, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp_out("mode2",     0, 1, 1, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); exp_out("sw_halt",   1, 1, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp_out("sw_drain",  2, 1, 0, 0, 0, 1, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
